// File: rtl/apu_pkg.sv
// Shared APU channel definitions: register map, length-counter lookup and
// default widths. Imported by the triangle controller and its sub-modules.
package apu_pkg;

  localparam int unsigned ADDR_W     = 2;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned LEN_IDX_W  = 5;
  localparam int unsigned TONE_W_DEF = 10;
  localparam int unsigned LIN_W_DEF  = 7;

  // Register select values seen on the channel register bus.
  typedef enum logic [ADDR_W-1:0] {
    REG_LINEAR  = 2'd0,
    REG_UNUSED  = 2'd1,
    REG_TONE_LO = 2'd2,
    REG_TONE_HI = 2'd3
  } reg_addr_e;

  // Length-counter load values, indexed by the 5-bit field of the tone-high write.
  localparam logic [LEN_W-1:0] LEN_LUT [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  // Length lookup helper so callers need not touch the array directly.
  function automatic logic [LEN_W-1:0] len_lookup(input logic [LEN_IDX_W-1:0] idx);
    return LEN_LUT[idx];
  endfunction

endpackage

// File: rtl/triangle_ctrl_if.sv
// Channel register write bus.
//   reg_wr_in   : single-cycle write strobe
//   reg_addr_in : register select (see apu_pkg::reg_addr_e)
//   reg_data_in : write data
// master drives the bus (CPU side); slave receives it (channel side).
interface triangle_ctrl_if;
  import apu_pkg::*;

  logic              reg_wr_in;
  logic [ADDR_W-1:0] reg_addr_in;
  logic [DATA_W-1:0] reg_data_in;

  modport master (output reg_wr_in, output reg_addr_in, output reg_data_in);
  modport slave  (input  reg_wr_in, input  reg_addr_in, input  reg_data_in);

endinterface

// File: rtl/apu_length_counter.sv
// APU length counter shared by the tone channels.
//   clk_in / rst_in   : clock, synchronous active-low reset
//   load_in, idx_in   : load strobe and lookup index
//   halt_in           : freezes the count on half-frame ticks
//   enable_in         : channel enable; low forces the count to zero
//   half_frame_in     : half-frame decrement tick
//   count_out         : registered count
//   nonzero_c         : combinational count != 0
module apu_length_counter
  import apu_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 load_in,
  input  logic [LEN_IDX_W-1:0] idx_in,
  input  logic                 halt_in,
  input  logic                 enable_in,
  input  logic                 half_frame_in,
  output logic [LEN_W-1:0]     count_out,
  output logic                 nonzero_c
);

  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] w_count_nxt;

  // Priority: disable clears, then load, then saturating decrement.
  always_comb begin
    w_count_nxt = r_count;
    if (!enable_in) begin
      w_count_nxt = '0;
    end else if (load_in) begin
      w_count_nxt = len_lookup(idx_in);
    end else if (half_frame_in && !halt_in && (r_count != '0)) begin
      w_count_nxt = r_count - LEN_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign count_out = r_count;
  assign nonzero_c = (r_count != '0);

endmodule

// File: rtl/triangle_ctrl.sv
// Triangle channel controller: register file, linear counter, length counter
// and phase-step gating for the triangle tone generator.
//   clk_in, rst_in     : clock, synchronous active-low reset
//   bus                : register write bus (slave)
//   enable_in          : channel enable from the status register
//   quarter_frame_in   : linear-counter tick
//   half_frame_in      : length-counter tick
//   step_in            : raw sample-rate step strobe
//   tone_out           : tone period to the generator
//   step_out           : gated step strobe (generator holds phase when muted)
//   active_out         : length counter nonzero, registered
module triangle_ctrl
  import apu_pkg::*;
#(
  parameter int unsigned TONE_W = TONE_W_DEF,
  parameter int unsigned LIN_W  = LIN_W_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  triangle_ctrl_if.slave    bus,
  input  logic              enable_in,
  input  logic              quarter_frame_in,
  input  logic              half_frame_in,
  input  logic              step_in,
  output logic [TONE_W-1:0] tone_out,
  output logic              step_out,
  output logic              active_out
);

  logic              r_control;
  logic [LIN_W-1:0]  r_reload_val;
  logic [LIN_W-1:0]  r_linear_cnt;
  logic              r_reload_flag;
  logic [TONE_W-1:0] r_tone;
  logic              r_step;
  logic              r_active;

  logic              w_control_nxt;
  logic [LIN_W-1:0]  w_reload_val_nxt;
  logic [LIN_W-1:0]  w_linear_nxt;
  logic              w_reload_flag_nxt;
  logic [TONE_W-1:0] w_tone_nxt;
  logic              w_len_load;
  logic [LEN_W-1:0]  w_len_cnt;
  logic              w_len_nz;
  logic              w_step_c;
  reg_addr_e         w_addr;

  assign w_addr = reg_addr_e'(bus.reg_addr_in);

  // Register file decode plus linear counter; tick logic reads only current
  // register state, so a coincident write affects the following tick.
  always_comb begin
    w_control_nxt     = r_control;
    w_reload_val_nxt  = r_reload_val;
    w_linear_nxt      = r_linear_cnt;
    w_reload_flag_nxt = r_reload_flag;
    w_tone_nxt        = r_tone;
    w_len_load        = 1'b0;

    if (quarter_frame_in) begin
      if (r_reload_flag) begin
        w_linear_nxt = r_reload_val;
      end else if (r_linear_cnt != '0) begin
        w_linear_nxt = r_linear_cnt - LIN_W'(1);
      end
      if (!r_control) begin
        w_reload_flag_nxt = 1'b0;
      end
    end

    if (bus.reg_wr_in) begin
      case (w_addr)
        REG_LINEAR: begin
          w_control_nxt    = bus.reg_data_in[7];
          w_reload_val_nxt = bus.reg_data_in[LIN_W-1:0];
        end
        REG_TONE_LO: begin
          w_tone_nxt[7:0] = bus.reg_data_in;
        end
        REG_TONE_HI: begin
          w_tone_nxt[TONE_W-1:8] = bus.reg_data_in[TONE_W-9:0];
          // Write after the tick clear so the flag always ends set.
          w_reload_flag_nxt      = 1'b1;
          w_len_load             = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // tone < 2 is ultrasonic and is muted rather than forwarded.
  assign w_step_c = step_in && (r_linear_cnt != '0) && w_len_nz &&
                    (r_tone >= TONE_W'(2));

  apu_length_counter u_len (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .load_in       (w_len_load),
    .idx_in        (bus.reg_data_in[7:3]),
    .halt_in       (r_control),
    .enable_in     (enable_in),
    .half_frame_in (half_frame_in),
    .count_out     (w_len_cnt),
    .nonzero_c     (w_len_nz)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_control     <= 1'b0;
      r_reload_val  <= '0;
      r_linear_cnt  <= '0;
      r_reload_flag <= 1'b0;
      r_tone        <= '0;
      r_step        <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_control     <= w_control_nxt;
      r_reload_val  <= w_reload_val_nxt;
      r_linear_cnt  <= w_linear_nxt;
      r_reload_flag <= w_reload_flag_nxt;
      r_tone        <= w_tone_nxt;
      r_step        <= w_step_c;
      r_active      <= w_len_nz;
    end
  end

  assign tone_out   = r_tone;
  assign step_out   = r_step;
  assign active_out = r_active;

endmodule

// File: tb/tb_triangle_ctrl.sv
// Directed self-checking bench for triangle_ctrl.
module tb_triangle_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       enable_in;
  logic       quarter_frame_in;
  logic       half_frame_in;
  logic       step_in;
  logic [9:0] tone_out;
  logic       step_out;
  logic       active_out;

  int checks   = 0;
  int failures = 0;

  triangle_ctrl_if u_if ();

  triangle_ctrl dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .bus              (u_if.slave),
    .enable_in        (enable_in),
    .quarter_frame_in (quarter_frame_in),
    .half_frame_in    (half_frame_in),
    .step_in          (step_in),
    .tone_out         (tone_out),
    .step_out         (step_out),
    .active_out       (active_out)
  );

  always #5 clk_in = ~clk_in;

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    u_if.reg_wr_in   = 1'b1;
    u_if.reg_addr_in = addr;
    u_if.reg_data_in = data;
    tick();
    u_if.reg_wr_in   = 1'b0;
  endtask

  task automatic quarter();
    quarter_frame_in = 1'b1;
    tick();
    quarter_frame_in = 1'b0;
  endtask

  task automatic half();
    half_frame_in = 1'b1;
    tick();
    half_frame_in = 1'b0;
  endtask

  task automatic step_pulse();
    step_in = 1'b1;
    tick();
    step_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
    tick();
    checks++;
    if (tone_out !== 10'd0 || step_out !== 1'b0 || active_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: tone=%h step=%b active=%b required 000/0/0",
               tone_out, step_out, active_out);
    end
    // Idle stepping with no writes never produces a step.
    for (int i = 0; i < 16; i++) begin
      step_in = ((i % 4) == 0);
      tick();
      checks++;
      if (step_out !== 1'b0 || active_out !== 1'b0 || tone_out !== 10'd0) begin
        failures++;
        $display("FAIL idle_step cyc%0d: step=%b active=%b tone=%h required 0/0/000",
                 i, step_out, active_out, tone_out);
      end
    end
    step_in = 1'b0;
  endtask

  task automatic test_basic();
    enable_in = 1'b1;
    wr(2'd0, 8'h05);
    wr(2'd2, 8'h40);
    wr(2'd3, 8'h08);
    checks++;
    if (tone_out !== 10'h040) begin
      failures++;
      $display("FAIL basic_tone: got %h required 040", tone_out);
    end
    checks++;
    if (dut.w_len_cnt !== 8'd254) begin
      failures++;
      $display("FAIL basic_len_load: got %0d required 254", dut.w_len_cnt);
    end
    tick();
    checks++;
    if (active_out !== 1'b1) begin
      failures++;
      $display("FAIL basic_active: got %b required 1", active_out);
    end
    // Addr 1 is a hole in the map: nothing changes.
    wr(2'd1, 8'hFF);
    checks++;
    if (tone_out !== 10'h040 || dut.r_control !== 1'b0 || dut.r_reload_val !== 7'd5) begin
      failures++;
      $display("FAIL unused_addr: tone=%h ctl=%b rv=%0d required 040/0/5",
               tone_out, dut.r_control, dut.r_reload_val);
    end
    quarter();
    checks++;
    if (dut.r_linear_cnt !== 7'd5 || dut.r_reload_flag !== 1'b0) begin
      failures++;
      $display("FAIL basic_linear: lin=%0d flag=%b required 5/0",
               dut.r_linear_cnt, dut.r_reload_flag);
    end
    for (int p = 0; p < 2; p++) begin
      checks++;
      if (step_out !== 1'b0) begin
        failures++;
        $display("FAIL basic_step_pre%0d: got %b required 0", p, step_out);
      end
      step_pulse();
      checks++;
      if (step_out !== 1'b1) begin
        failures++;
        $display("FAIL basic_step_pulse%0d: got %b required 1", p, step_out);
      end
      tick();
      checks++;
      if (step_out !== 1'b0) begin
        failures++;
        $display("FAIL basic_step_width%0d: got %b required 0", p, step_out);
      end
    end
  endtask

  task automatic test_linear();
    for (int i = 0; i < 5; i++) begin
      quarter();
      checks++;
      if (dut.r_linear_cnt !== 7'(4 - i)) begin
        failures++;
        $display("FAIL linear_dec%0d: got %0d required %0d", i, dut.r_linear_cnt, 4 - i);
      end
    end
    quarter();
    checks++;
    if (dut.r_linear_cnt !== 7'd0) begin
      failures++;
      $display("FAIL linear_floor: got %0d required 0", dut.r_linear_cnt);
    end
    step_pulse();
    checks++;
    if (step_out !== 1'b0) begin
      failures++;
      $display("FAIL linear_zero_mute: got %b required 0", step_out);
    end
    // control=1 holds the reload flag so every quarter tick reloads.
    wr(2'd0, 8'h85);
    wr(2'd3, 8'h08);
    for (int i = 0; i < 3; i++) begin
      quarter();
      checks++;
      if (dut.r_linear_cnt !== 7'd5 || dut.r_reload_flag !== 1'b1) begin
        failures++;
        $display("FAIL linear_hold%0d: lin=%0d flag=%b required 5/1",
                 i, dut.r_linear_cnt, dut.r_reload_flag);
      end
    end
    // Halted length counter ignores half ticks.
    half();
    checks++;
    if (dut.w_len_cnt !== 8'd254) begin
      failures++;
      $display("FAIL len_halt: got %0d required 254", dut.w_len_cnt);
    end
  endtask

  task automatic test_length();
    wr(2'd0, 8'h05);
    wr(2'd3, 8'h18);
    quarter();
    tick();
    checks++;
    if (dut.w_len_cnt !== 8'd2 || active_out !== 1'b1) begin
      failures++;
      $display("FAIL len_idx3: len=%0d active=%b required 2/1", dut.w_len_cnt, active_out);
    end
    half();
    tick();
    checks++;
    if (dut.w_len_cnt !== 8'd1 || active_out !== 1'b1) begin
      failures++;
      $display("FAIL len_half1: len=%0d active=%b required 1/1", dut.w_len_cnt, active_out);
    end
    half();
    checks++;
    if (active_out !== 1'b1) begin
      failures++;
      $display("FAIL active_lag: got %b required 1", active_out);
    end
    tick();
    checks++;
    if (dut.w_len_cnt !== 8'd0 || active_out !== 1'b0) begin
      failures++;
      $display("FAIL len_half2: len=%0d active=%b required 0/0", dut.w_len_cnt, active_out);
    end
    step_pulse();
    checks++;
    if (step_out !== 1'b0) begin
      failures++;
      $display("FAIL len_zero_mute: got %b required 0", step_out);
    end
    half();
    checks++;
    if (dut.w_len_cnt !== 8'd0) begin
      failures++;
      $display("FAIL len_no_wrap: got %0d required 0", dut.w_len_cnt);
    end
  endtask

  task automatic test_simultaneous();
    half_frame_in    = 1'b1;
    u_if.reg_wr_in   = 1'b1;
    u_if.reg_addr_in = 2'd3;
    u_if.reg_data_in = 8'h00;
    tick();
    half_frame_in    = 1'b0;
    u_if.reg_wr_in   = 1'b0;
    checks++;
    if (dut.w_len_cnt !== 8'd10) begin
      failures++;
      $display("FAIL load_vs_half: got %0d required 10", dut.w_len_cnt);
    end
    // Quarter tick with a clear flag and coincident addr3 write: decrement, flag set.
    quarter();
    checks++;
    if (dut.r_reload_flag !== 1'b0 || dut.r_linear_cnt !== 7'd5) begin
      failures++;
      $display("FAIL pre_q_write: flag=%b lin=%0d required 0/5",
               dut.r_reload_flag, dut.r_linear_cnt);
    end
    quarter_frame_in = 1'b1;
    u_if.reg_wr_in   = 1'b1;
    u_if.reg_addr_in = 2'd3;
    u_if.reg_data_in = 8'h00;
    tick();
    quarter_frame_in = 1'b0;
    u_if.reg_wr_in   = 1'b0;
    checks++;
    if (dut.r_linear_cnt !== 7'd4 || dut.r_reload_flag !== 1'b1) begin
      failures++;
      $display("FAIL q_vs_write: lin=%0d flag=%b required 4/1",
               dut.r_linear_cnt, dut.r_reload_flag);
    end
    enable_in = 1'b0;
    tick();
    checks++;
    if (dut.w_len_cnt !== 8'd0) begin
      failures++;
      $display("FAIL disable_clear: got %0d required 0", dut.w_len_cnt);
    end
    wr(2'd3, 8'h08);
    checks++;
    if (dut.w_len_cnt !== 8'd0) begin
      failures++;
      $display("FAIL disabled_load: got %0d required 0", dut.w_len_cnt);
    end
    enable_in = 1'b1;
  endtask

  task automatic test_tone_mute();
    wr(2'd0, 8'h05);
    wr(2'd2, 8'h01);
    wr(2'd3, 8'h00);
    quarter();
    checks++;
    if (tone_out !== 10'h001 || dut.r_linear_cnt !== 7'd5 || dut.w_len_cnt !== 8'd10) begin
      failures++;
      $display("FAIL mute_setup: tone=%h lin=%0d len=%0d required 001/5/10",
               tone_out, dut.r_linear_cnt, dut.w_len_cnt);
    end
    step_pulse();
    checks++;
    if (step_out !== 1'b0) begin
      failures++;
      $display("FAIL tone1_mute: got %b required 0", step_out);
    end
    wr(2'd2, 8'h02);
    step_pulse();
    checks++;
    if (step_out !== 1'b1) begin
      failures++;
      $display("FAIL tone2_resume: got %b required 1", step_out);
    end
    // Reset mid-stream with a step pending.
    step_in = 1'b1;
    rst_in  = 1'b0;
    tick();
    step_in = 1'b0;
    checks++;
    if (step_out !== 1'b0 || tone_out !== 10'd0 || active_out !== 1'b0 ||
        dut.r_linear_cnt !== 7'd0 || dut.w_len_cnt !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset: step=%b tone=%h active=%b lin=%0d len=%0d required all 0",
               step_out, tone_out, active_out, dut.r_linear_cnt, dut.w_len_cnt);
    end
    rst_in = 1'b1;
    tick();
    checks++;
    if (step_out !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_step: got %b required 0", step_out);
    end
  endtask

  initial begin
    rst_in           = 1'b0;
    enable_in        = 1'b0;
    quarter_frame_in = 1'b0;
    half_frame_in    = 1'b0;
    step_in          = 1'b0;
    u_if.reg_wr_in   = 1'b0;
    u_if.reg_addr_in = 2'd0;
    u_if.reg_data_in = 8'h00;
    test_reset();
    test_basic();
    test_linear();
    test_length();
    test_simultaneous();
    test_tone_mute();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
